// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//
// Purpose : shared definitions for the serial-to-parallel deserializer.
//           Holds the receiver FSM state encoding and the default data word
//           width so that the RTL and anything built around it agree.
//
// Contents:
//   DEFAULT_WIDTH  - default data word width in bits (legal range 2..16)
//   shiftState_e   - receiver FSM states: IDLE, DATA, STOP
// ---------------------------------------------------------------------------
package shift_pkg;

   // Default number of data bits carried by one frame.
   localparam int DEFAULT_WIDTH = 4;

   // Receiver framing states: waiting for a start bit, collecting data
   // bits, and checking the stop bit.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } shiftState_e;

endpackage : shift_pkg

// File: rtl/shift_deserializer.sv
// ---------------------------------------------------------------------------
// shift_deserializer
//
// Purpose : receives frames from a shift-register transmitter and presents
//           each completed data word in a single-entry holding register with
//           a valid/ready handshake. A frame is a start bit (0), WIDTH data
//           bits, and a stop bit (1), one bit per cycle with s_valid=1.
//           Bit order (MSB or LSB first) is chosen per frame at the start bit.
//
// Parameters:
//   WIDTH      - data word width in bits, legal range 2..16
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   s_din      in   1      serial data bit
//   s_valid    in   1      s_din qualifier, one bit consumed per valid cycle
//   msb_first  in   1      1 = MSB first, 0 = LSB first (latched at start)
//   p_dout     out  WIDTH  holding register contents
//   p_valid    out  1      holding register holds an unconsumed word
//   p_ready    in   1      consumer takes p_dout when p_valid && p_ready
//   frame_err  out  1      one-cycle pulse: stop bit was 0
//   overrun    out  1      one-cycle pulse: finished word dropped, holder full
// ---------------------------------------------------------------------------
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_din,
   input  logic             s_valid,
   input  logic             msb_first,
   output logic [WIDTH-1:0] p_dout,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             frame_err,
   output logic             overrun
);

   // Counter must be able to hold WIDTH itself, hence WIDTH+1 values.
   localparam int CNT_W = $clog2(WIDTH + 1);

   shiftState_e      state_q;
   shiftState_e      state_d;

   logic [CNT_W-1:0] bitCnt_q;
   logic [CNT_W-1:0] bitCnt_d;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic             order_q;
   logic             order_d;
   logic [WIDTH-1:0] pDout_q;
   logic [WIDTH-1:0] pDout_d;
   logic             pValid_q;
   logic             pValid_d;
   logic             frameErr_q;
   logic             frameErr_d;
   logic             overrun_q;
   logic             overrun_d;

   logic             lastDataBit;
   logic             holderFree;

   // The bit being consumed this cycle is the final data bit of the word.
   assign lastDataBit = (bitCnt_q == CNT_W'(WIDTH - 1));

   // A new word may enter the holder if it is empty or is being drained
   // in the very same cycle.
   assign holderFree = !pValid_q || p_ready;

   // State register: the only place the FSM state is stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: only valid cycles can move the FSM, so idle gaps on
   // the serial line never disturb a frame in progress. STOP always falls
   // back to IDLE, which means a start bit is only recognised on the valid
   // cycle after the stop bit.
   always_comb begin
      state_d = state_q;
      if (s_valid) begin
         case (state_q)
            IDLE: begin
               if (!s_din) begin
                  state_d = DATA;
               end
            end
            DATA: begin
               if (lastDataBit) begin
                  state_d = STOP;
               end
            end
            STOP: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output / datapath next-value logic. The bit order is captured at the
   // start bit so a msb_first change mid-frame only affects the next frame.
   // A consumer handshake drains the holder unless a new word replaces it
   // in the same cycle, in which case the load wins and p_valid stays high.
   always_comb begin
      sr_d       = sr_q;
      bitCnt_d   = bitCnt_q;
      order_d    = order_q;
      pDout_d    = pDout_q;
      pValid_d   = pValid_q;
      frameErr_d = 1'b0;
      overrun_d  = 1'b0;

      if (pValid_q && p_ready) begin
         pValid_d = 1'b0;
      end

      if (s_valid) begin
         case (state_q)
            IDLE: begin
               if (!s_din) begin
                  bitCnt_d = '0;
                  order_d  = msb_first;
               end
            end
            DATA: begin
               if (order_q) begin
                  sr_d = {sr_q[WIDTH-2:0], s_din};
               end else begin
                  sr_d = {s_din, sr_q[WIDTH-1:1]};
               end
               bitCnt_d = bitCnt_q + CNT_W'(1);
            end
            STOP: begin
               if (s_din) begin
                  if (holderFree) begin
                     pDout_d  = sr_q;
                     pValid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frameErr_d = 1'b1;
               end
            end
            default: begin
               bitCnt_d = '0;
            end
         endcase
      end
   end

   // Datapath and registered outputs. Reset clears everything so a frame
   // interrupted by reset is simply forgotten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitCnt_q   <= '0;
         sr_q       <= '0;
         order_q    <= 1'b0;
         pDout_q    <= '0;
         pValid_q   <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         bitCnt_q   <= bitCnt_d;
         sr_q       <= sr_d;
         order_q    <= order_d;
         pDout_q    <= pDout_d;
         pValid_q   <= pValid_d;
         frameErr_q <= frameErr_d;
         overrun_q  <= overrun_d;
      end
   end

   assign p_dout    = pDout_q;
   assign p_valid   = pValid_q;
   assign frame_err = frameErr_q;
   assign overrun   = overrun_q;

endmodule : shift_deserializer

// File: tb/tb_shift_deserializer.sv
// ---------------------------------------------------------------------------
// tb_shift_deserializer
//
// Purpose : self-checking bench for shift_deserializer at WIDTH=4. A
//           behavioural model tracks frames as a list of received data bits
//           and builds each word arithmetically from bit positions; every
//           stimulus cycle compares all outputs with it. Fixed-vector tables
//           and short hand-written sequences cover the documented cases.
// ---------------------------------------------------------------------------
module tb_shift_deserializer;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         s_din;
   logic         s_valid;
   logic         msb_first;
   logic [W-1:0] p_dout;
   logic         p_valid;
   logic         p_ready;
   logic         frame_err;
   logic         overrun;

   int checks;
   int errors;
   int cycle;

   // Reference model state.
   bit           mInFrame;
   bit           mOrder;
   bit           mBits[$];
   logic [W-1:0] mDout;
   logic         mValid;
   logic         mFerr;
   logic         mOvr;

   typedef struct {
      logic         msb;
      logic [5:0]   bits;
      logic [W-1:0] expDout;
      logic         expValid;
      logic         expFerr;
   } vector_t;

   vector_t vecs[5];

   shift_deserializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_din     (s_din),
      .s_valid   (s_valid),
      .msb_first (msb_first),
      .p_dout    (p_dout),
      .p_valid   (p_valid),
      .p_ready   (p_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cycle, actual, expected);
      end
   endtask

   // Model update for one clock edge, driven purely by the framing rules.
   task automatic modelStep(input logic din, input logic valid, input logic ready);
      logic         load;
      logic [W-1:0] word;
      load  = 1'b0;
      word  = '0;
      mFerr = 1'b0;
      mOvr  = 1'b0;
      if (valid) begin
         if (!mInFrame) begin
            if (!din) begin
               mInFrame = 1'b1;
               mOrder   = msb_first;
               mBits.delete();
            end
         end else if (mBits.size() < W) begin
            mBits.push_back(din);
         end else begin
            mInFrame = 1'b0;
            if (din) begin
               if (!mValid || ready) begin
                  for (int i = 0; i < W; i++) begin
                     if (mBits[i]) begin
                        if (mOrder) word = word | W'(1 << (W - 1 - i));
                        else        word = word | W'(1 << i);
                     end
                  end
                  load = 1'b1;
               end else begin
                  mOvr = 1'b1;
               end
            end else begin
               mFerr = 1'b1;
            end
         end
      end
      if (load) begin
         mDout  = word;
         mValid = 1'b1;
      end else if (mValid && ready) begin
         mValid = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, advance the model on the edge and compare
   // every output against it on the following falling edge.
   task automatic applyStimulus(input logic din, input logic valid, input logic ready, input logic msb);
      s_din     = din;
      s_valid   = valid;
      p_ready   = ready;
      msb_first = msb;
      @(posedge clk);
      modelStep(din, valid, ready);
      cycle++;
      @(negedge clk);
      checkOutput("p_dout",    16'(p_dout),    16'(mDout));
      checkOutput("p_valid",   16'(p_valid),   16'(mValid));
      checkOutput("frame_err", 16'(frame_err), 16'(mFerr));
      checkOutput("overrun",   16'(overrun),   16'(mOvr));
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic doReset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      p_ready = 1'b0;
      #1;
      checkOutput("rst_p_dout",    16'(p_dout),    16'h0);
      checkOutput("rst_p_valid",   16'(p_valid),   16'h0);
      checkOutput("rst_frame_err", 16'(frame_err), 16'h0);
      checkOutput("rst_overrun",   16'(overrun),   16'h0);
      mInFrame = 1'b0;
      mOrder   = 1'b0;
      mBits.delete();
      mDout    = '0;
      mValid   = 1'b0;
      mFerr    = 1'b0;
      mOvr     = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   // Send a six-bit frame, first element is bits[5]; p_ready is only
   // raised on the stop-bit cycle when requested.
   task automatic sendFrame(input logic msb, input logic [5:0] bits, input logic readyOnStop, input logic withGaps);
      for (int i = 5; i >= 0; i--) begin
         if (withGaps) applyStimulus(1'($urandom), 1'b0, 1'b0, msb);
         applyStimulus(bits[i], 1'b1, (i == 0) ? readyOnStop : 1'b0, msb);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cycle     = 0;
      rst_n     = 1'b0;
      s_din     = 1'b1;
      s_valid   = 1'b0;
      msb_first = 1'b0;
      p_ready   = 1'b0;

      vecs[0] = '{msb: 1'b0, bits: 6'b010111, expDout: 4'b1101, expValid: 1'b1, expFerr: 1'b0};
      vecs[1] = '{msb: 1'b1, bits: 6'b011011, expDout: 4'b1101, expValid: 1'b1, expFerr: 1'b0};
      vecs[2] = '{msb: 1'b0, bits: 6'b010110, expDout: 4'b0000, expValid: 1'b0, expFerr: 1'b1};
      vecs[3] = '{msb: 1'b1, bits: 6'b000011, expDout: 4'b0001, expValid: 1'b1, expFerr: 1'b0};
      vecs[4] = '{msb: 1'b0, bits: 6'b000011, expDout: 4'b1000, expValid: 1'b1, expFerr: 1'b0};

      @(negedge clk);
      doReset();

      // Table-driven frames, each from a clean reset.
      for (int v = 0; v < 5; v++) begin
         doReset();
         sendFrame(vecs[v].msb, vecs[v].bits, 1'b0, 1'b0);
         checkOutput("vec_dout",  16'(p_dout),    16'(vecs[v].expDout));
         checkOutput("vec_valid", 16'(p_valid),   16'(vecs[v].expValid));
         checkOutput("vec_ferr",  16'(frame_err), 16'(vecs[v].expFerr));
         checkOutput("vec_ovr",   16'(overrun),   16'h0);
      end

      // Bad stop bit, then a good frame decodes normally.
      doReset();
      sendFrame(1'b0, 6'b010110, 1'b0, 1'b0);
      checkOutput("badstop_ferr",  16'(frame_err), 16'h1);
      checkOutput("badstop_valid", 16'(p_valid),   16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("badstop_pulse", 16'(frame_err), 16'h0);
      sendFrame(1'b0, 6'b010111, 1'b0, 1'b0);
      checkOutput("after_bad_dout", 16'(p_dout), 16'hD);

      // Overrun: second word dropped while the holder is still full.
      doReset();
      sendFrame(1'b0, 6'b010111, 1'b0, 1'b0);
      sendFrame(1'b0, 6'b011001, 1'b0, 1'b0);
      checkOutput("ovr_pulse", 16'(overrun), 16'h1);
      checkOutput("ovr_dout",  16'(p_dout),  16'hD);
      checkOutput("ovr_valid", 16'(p_valid), 16'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr_oneshot", 16'(overrun), 16'h0);

      // Same, but the consumer drains on the stop cycle: the new word loads.
      sendFrame(1'b0, 6'b011001, 1'b1, 1'b0);
      checkOutput("drain_dout",  16'(p_dout),  16'h3);
      checkOutput("drain_valid", 16'(p_valid), 16'h1);
      checkOutput("drain_ovr",   16'(overrun), 16'h0);

      // Plain handshake clears p_valid and holds p_dout.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("hs_valid", 16'(p_valid), 16'h0);
      checkOutput("hs_dout",  16'(p_dout),  16'h3);

      // Gaps inside a frame do not change the result.
      doReset();
      sendFrame(1'b0, 6'b010111, 1'b0, 1'b1);
      checkOutput("gap_dout",  16'(p_dout),  16'hD);
      checkOutput("gap_valid", 16'(p_valid), 16'h1);

      // msb_first flipped after the start bit is ignored for this frame.
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("order_latch_dout", 16'(p_dout), 16'hD);

      // Reset after two data bits, then a fresh frame decodes.
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      doReset();
      sendFrame(1'b1, 6'b011011, 1'b0, 1'b0);
      checkOutput("post_rst_dout",  16'(p_dout),  16'hD);
      checkOutput("post_rst_valid", 16'(p_valid), 16'h1);

      // Randomized traffic against the model.
      doReset();
      for (int n = 0; n < 800; n++) begin
         applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_shift_deserializer
